// File: rtl/fetch_decode_buffer_pkg.sv
// fetch_decode_buffer_pkg
// Shared constants and types for the fetch/decode decoupling buffer.
//   FDB_NOP_INSTR  : bubble encoding presented to decode when nothing is buffered
//   FDB_HALT_INSTR : halt encoding (all zeros)
//   INSTR_W        : instruction / PC width
//   fetch_entry_t  : one buffered fetch result {instr, incpc, err}
package fetch_decode_buffer_pkg;

  localparam int          INSTR_W        = 16;
  localparam logic [15:0] FDB_NOP_INSTR  = 16'h0800;
  localparam logic [15:0] FDB_HALT_INSTR = 16'h0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] incpc;
    logic               err;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_decode_buffer_storage.sv
// fdb_storage
// DEPTH x ENTRY_W register array backing the fetch/decode buffer.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset (array cleared)
//   wr_en, wr_ptr     : write enable and slot index
//   wr_data           : packed fetch_entry_t to store
//   rd_ptr, rd_data   : combinational read of the addressed slot
module fdb_storage
  import fetch_decode_buffer_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_ptr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [PTR_W-1:0]   rd_ptr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem_r [DEPTH];

  // Slot array: cleared on reset, written by the top's push strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENTRY_W{1'b0}};
      end
    end else if (wr_en) begin
      mem_r[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer
// Small FIFO decoupling fetch from decode. Fetch pushes {instr, incpc, err}
// when in_ready; decode sees the oldest entry (or a NOP bubble when empty) and
// pops it with out_ready. flush discards everything and wins over push/pop.
// Ports:
//   clk, rst (async active-low)
//   in_valid, in_instr, in_incpc, in_err, in_ready     : fetch side
//   out_valid, out_instr, out_incpc, out_err, out_ready : decode side
//   flush : redirect, drops all entries and any same-cycle push
//   count : current occupancy (0..DEPTH)
// Optional (macro FDB_PERF_CNT_EN): bubble_cnt, full_cnt saturating counters.
module fetch_decode_buffer
  import fetch_decode_buffer_pkg::*;
#(
  parameter  int          DEPTH     = 2,
  parameter  logic [15:0] NOP_INSTR = FDB_NOP_INSTR,
  localparam int          PTR_W     = $clog2(DEPTH),
  localparam int          CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [INSTR_W-1:0] in_incpc,
  input  logic               in_err,
  output logic               in_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [INSTR_W-1:0] out_incpc,
  output logic               out_err,
  input  logic               out_ready,
  input  logic               flush,
  output logic [CNT_W-1:0]   count
`ifdef FDB_PERF_CNT_EN
  ,
  output logic [15:0]        bubble_cnt,
  output logic [15:0]        full_cnt
`endif
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_s;
  logic               pop_s;
  fetch_entry_t       wr_entry_s;
  fetch_entry_t       head_s;
  logic [ENTRY_W-1:0] rd_data_s;

  // Both ready/valid come only from the occupancy register, so there is no
  // combinational path from out_ready to in_ready or from in_* to out_*.
  assign in_ready  = (count_r != FULL_CNT);
  assign out_valid = (count_r != {CNT_W{1'b0}});
  assign count     = count_r;

  assign push_s = in_valid & in_ready & ~flush;
  assign pop_s  = out_valid & out_ready & ~flush;

  assign wr_entry_s.instr = in_instr;
  assign wr_entry_s.incpc = in_incpc;
  assign wr_entry_s.err   = in_err;
  assign head_s           = fetch_entry_t'(rd_data_s);

  fdb_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_s),
    .wr_ptr  (wr_ptr_r),
    .wr_data (wr_entry_s),
    .rd_ptr  (rd_ptr_r),
    .rd_data (rd_data_s)
  );

  // Pointer and occupancy update; flush clears everything and beats push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head presentation: real entry when occupied, NOP bubble otherwise.
  always_comb begin
    out_instr = NOP_INSTR;
    out_incpc = {INSTR_W{1'b0}};
    out_err   = 1'b0;
    if (out_valid) begin
      out_instr = head_s.instr;
      out_incpc = head_s.incpc;
      out_err   = head_s.err;
    end else begin
      out_instr = NOP_INSTR;
      out_incpc = {INSTR_W{1'b0}};
      out_err   = 1'b0;
    end
  end

`ifdef FDB_PERF_CNT_EN
  logic [15:0] bubble_cnt_r;
  logic [15:0] full_cnt_r;

  // Saturating stall counters; deliberately insensitive to flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_r <= 16'h0000;
      full_cnt_r   <= 16'h0000;
    end else begin
      if (out_ready && !out_valid && (bubble_cnt_r != 16'hFFFF)) begin
        bubble_cnt_r <= bubble_cnt_r + 16'h0001;
      end
      if (in_valid && !in_ready && (full_cnt_r != 16'hFFFF)) begin
        full_cnt_r <= full_cnt_r + 16'h0001;
      end
    end
  end

  assign bubble_cnt = bubble_cnt_r;
  assign full_cnt   = full_cnt_r;
`else
  // Performance counters not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
module tb_fetch_decode_buffer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_instr;
  logic [15:0] in_incpc;
  logic        in_err;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_incpc;
  logic        out_err;
  logic        out_ready;
  logic        flush;
  logic [1:0]  count;
`ifdef FDB_PERF_CNT_EN
  logic [15:0] bubble_cnt;
  logic [15:0] full_cnt;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit saw_c123 = 1'b0;

  // Reference model: plain queue of {instr, incpc, err}.
  logic [32:0] q[$];

  fetch_decode_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_incpc  (in_incpc),
    .in_err    (in_err),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_incpc (out_incpc),
    .out_err   (out_err),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
`ifdef FDB_PERF_CNT_EN
    ,
    .bubble_cnt(bubble_cnt),
    .full_cnt  (full_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Model update on the active edge, from the same inputs the DUT sees.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      bit can_push, can_pop;
      can_push = in_valid && (q.size() != DEPTH) && !flush;
      can_pop  = out_ready && (q.size() != 0) && !flush;
      if (flush) q.delete();
      else begin
        if (can_pop) void'(q.pop_front());
        if (can_push) q.push_back({in_instr, in_incpc, in_err});
      end
    end
  end

  always @(negedge rst) q.delete();

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [32:0] h;
    h = (q.size() != 0) ? q[0] : {16'h0800, 16'h0000, 1'b0};
    check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    check("in_ready",  {31'd0, in_ready},  {31'd0, q.size() != DEPTH});
    check("count",     {30'd0, count},     q.size());
    check("out_instr", {16'd0, out_instr}, {16'd0, h[32:17]});
    check("out_incpc", {16'd0, out_incpc}, {16'd0, h[16:1]});
    check("out_err",   {31'd0, out_err},   {31'd0, h[0]});
    if (out_instr == 16'hC123) saw_c123 = 1'b1;
  end

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic e, input logic ordy, input logic fl);
    in_valid = v; in_instr = ins; in_incpc = pc; in_err = e;
    out_ready = ordy; flush = fl;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_instr = 16'h0; in_incpc = 16'h0; in_err = 1'b0;
    out_ready = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", {16'd0, out_instr}, 32'h0800);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    // Idle after reset release.
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_out_instr", {16'd0, out_instr}, 32'h0800);
    check("idle_out_incpc", {16'd0, out_incpc}, 32'h0000);
    check("idle_count",     {30'd0, count},     32'd0);

    // Streaming with out_ready held high.
    drive(1'b1, 16'h4001, 16'h0002, 1'b0, 1'b1, 1'b0);
    check("stream1_instr", {16'd0, out_instr}, 32'h4001);
    check("stream1_count", {30'd0, count}, 32'd1);
    drive(1'b1, 16'h4002, 16'h0004, 1'b0, 1'b1, 1'b0);
    check("stream2_instr", {16'd0, out_instr}, 32'h4002);
    check("stream2_incpc", {16'd0, out_incpc}, 32'h0004);
    check("stream2_count", {30'd0, count}, 32'd1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    check("stream_empty", {30'd0, count}, 32'd0);

    // Fill and backpressure.
    drive(1'b1, 16'hA001, 16'h0010, 1'b0, 1'b0, 1'b0);
    check("fill1_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 16'hA002, 16'h0012, 1'b0, 1'b0, 1'b0);
    check("fill2_ready", {31'd0, in_ready}, 32'd0);
    check("fill2_count", {30'd0, count}, 32'd2);
    drive(1'b1, 16'hA003, 16'h0014, 1'b0, 1'b0, 1'b0);
    check("fill3_count", {30'd0, count}, 32'd2);
    check("fill3_head",  {16'd0, out_instr}, 32'hA001);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    check("drain1_instr", {16'd0, out_instr}, 32'hA002);
    check("drain1_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    check("drain2_count", {30'd0, count}, 32'd0);

    // Flush with a concurrent push at full occupancy.
    drive(1'b1, 16'hB001, 16'h0020, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'hB002, 16'h0022, 1'b0, 1'b0, 1'b0);
    check("preflush_count", {30'd0, count}, 32'd2);
    drive(1'b1, 16'hC123, 16'h0030, 1'b0, 1'b0, 1'b1);
    check("flush_count", {30'd0, count}, 32'd0);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_instr", {16'd0, out_instr}, 32'h0800);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Error propagation across pointer wrap with random out_ready.
    for (int i = 0; i < 5; i++) begin
      bit accepted;
      int budget;
      accepted = 1'b0;
      budget = 0;
      while (!accepted && budget < 50) begin
        accepted = in_ready;
        drive(1'b1, 16'h5000 + 16'(i), 16'h0100 + 16'(2 * i), i[0], 1'($urandom_range(0, 1)), 1'b0);
        budget++;
      end
      if (!accepted) check("wrap_push_timeout", 32'd0, 32'd1);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    check("wrap_drained", {30'd0, count}, 32'd0);

    // Async reset between edges.
    drive(1'b1, 16'hD001, 16'h0040, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'hD002, 16'h0042, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("prereset_count", {30'd0, count}, 32'd2);
    #1;
    rst = 1'b0;
    #1;
    check("async_count", {30'd0, count}, 32'd0);
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_instr", {16'd0, out_instr}, 32'h0800);
    @(negedge clk); rst = 1'b1;
    drive(1'b1, 16'hE001, 16'h0050, 1'b1, 1'b0, 1'b0);
    check("post_reset_push", {16'd0, out_instr}, 32'hE001);
    check("post_reset_err",  {31'd0, out_err}, 32'd1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

    check("c123_never_seen", {31'd0, saw_c123}, 32'd0);
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
